// File: rtl/lock_controller_if.sv
// Signal bundle between the lock sequencer and the waterway/chamber plant.
// master drives requests and level samples; slave (the controller) drives gates and valves.
interface lock_controller_if #(
  parameter int unsigned LEVEL_W = 8
);
  logic               arrive_left;
  logic               arrive_right;
  logic               gondola_in;
  logic               gondola_out;
  logic [LEVEL_W-1:0] left_level;
  logic [LEVEL_W-1:0] right_level;
  logic [LEVEL_W-1:0] chamber_level;
  logic               left_gate_open;
  logic               right_gate_open;
  logic               fill_valve;
  logic               drain_valve;
  logic               busy;

  modport master (
    output arrive_left, arrive_right, gondola_in, gondola_out,
           left_level, right_level, chamber_level,
    input  left_gate_open, right_gate_open, fill_valve, drain_valve, busy
  );

  modport slave (
    input  arrive_left, arrive_right, gondola_in, gondola_out,
           left_level, right_level, chamber_level,
    output left_gate_open, right_gate_open, fill_valve, drain_valve, busy
  );
endinterface

// File: rtl/lock_controller.sv
// Canal lock chamber sequencer: round-robin side arbitration, level equalisation,
// entry/exit gate control with an entry-gate timeout.
module lock_controller #(
  parameter int unsigned LEVEL_W      = 8,
  parameter int unsigned TOL          = 3,
  parameter int unsigned GATE_TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              reset,
  lock_controller_if.slave  bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] EQ_IN    = 3'd1;
  localparam logic [2:0] OPEN_IN  = 3'd2;
  localparam logic [2:0] EQ_OUT   = 3'd3;
  localparam logic [2:0] OPEN_OUT = 3'd4;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  localparam int unsigned   TW    = (GATE_TIMEOUT > 1) ? $clog2(GATE_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST = TW'(GATE_TIMEOUT - 1);

  localparam logic [LEVEL_W:0] TOL_X = (LEVEL_W + 1)'(TOL);
  localparam logic [LEVEL_W:0] MAX_X = {1'b0, {LEVEL_W{1'b1}}};

  logic [2:0]    state, nstate;
  logic          side, nside;
  logic          last_served, nlast;
  logic          pend_l, pend_r;
  logic          clr_l, clr_r;
  logic [TW-1:0] timer, ntimer;
  logic          eff_l, eff_r;
  logic          cur_below, cur_above, cur_eq;
  logic          nxt_below, nxt_above;
  logic [LEVEL_W-1:0] cur_target, nxt_target;

  // Window test done one bit wider so the T-TOL / T+TOL bounds saturate instead of wrapping.
  function automatic logic [1:0] window(input logic [LEVEL_W-1:0] c,
                                        input logic [LEVEL_W-1:0] t);
    logic [LEVEL_W:0] tx, cx, lo, hi;
    tx = {1'b0, t};
    cx = {1'b0, c};
    lo = (tx >= TOL_X) ? tx - TOL_X : '0;
    hi = tx + TOL_X;
    if (hi > MAX_X) hi = MAX_X;
    return {cx < lo, cx > hi};
  endfunction

  function automatic logic [LEVEL_W-1:0] side_level(input logic s);
    return (s == LEFT) ? bus.left_level : bus.right_level;
  endfunction

  function automatic logic entry_phase(input logic [2:0] st);
    return (st == EQ_IN) || (st == OPEN_IN);
  endfunction

  always_comb begin
    cur_target = entry_phase(state) ? side_level(side) : side_level(~side);
    {cur_below, cur_above} = window(bus.chamber_level, cur_target);
    cur_eq = !cur_below && !cur_above;
  end

  always_comb begin
    eff_l  = pend_l | bus.arrive_left;
    eff_r  = pend_r | bus.arrive_right;
    nstate = state;
    nside  = side;
    nlast  = last_served;
    ntimer = timer;
    clr_l  = 1'b0;
    clr_r  = 1'b0;
    case (state)
      IDLE: begin
        if (eff_l || eff_r) begin
          nside  = (eff_l && eff_r) ? ~last_served : (eff_l ? LEFT : RIGHT);
          nlast  = nside;
          nstate = EQ_IN;
        end
      end
      EQ_IN: begin
        if (cur_eq) begin
          nstate = OPEN_IN;
          ntimer = '0;
        end
      end
      OPEN_IN: begin
        if (bus.gondola_in) begin
          nstate = EQ_OUT;
          clr_l  = (side == LEFT);
          clr_r  = (side == RIGHT);
        end else if (!cur_eq) begin
          nstate = EQ_IN;
        end else if (timer == TLAST) begin
          nstate = IDLE;
          clr_l  = (side == LEFT);
          clr_r  = (side == RIGHT);
        end else begin
          ntimer = timer + 1'b1;
        end
      end
      EQ_OUT: begin
        if (cur_eq) nstate = OPEN_OUT;
      end
      OPEN_OUT: begin
        if (bus.gondola_out) nstate = IDLE;
        else if (!cur_eq)    nstate = EQ_OUT;
      end
      default: nstate = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as state.
  always_comb begin
    nxt_target = entry_phase(nstate) ? side_level(nside) : side_level(~nside);
    {nxt_below, nxt_above} = window(bus.chamber_level, nxt_target);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      side                <= LEFT;
      last_served         <= RIGHT;
      pend_l              <= 1'b0;
      pend_r              <= 1'b0;
      timer               <= '0;
      bus.left_gate_open  <= 1'b0;
      bus.right_gate_open <= 1'b0;
      bus.fill_valve      <= 1'b0;
      bus.drain_valve     <= 1'b0;
      bus.busy            <= 1'b0;
    end else begin
      state               <= nstate;
      side                <= nside;
      last_served         <= nlast;
      timer               <= ntimer;
      pend_l              <= eff_l & ~clr_l;
      pend_r              <= eff_r & ~clr_r;
      bus.left_gate_open  <= ((nstate == OPEN_IN)  && (nside == LEFT)) ||
                             ((nstate == OPEN_OUT) && (nside == RIGHT));
      bus.right_gate_open <= ((nstate == OPEN_IN)  && (nside == RIGHT)) ||
                             ((nstate == OPEN_OUT) && (nside == LEFT));
      bus.fill_valve      <= ((nstate == EQ_IN) || (nstate == EQ_OUT)) && nxt_below;
      bus.drain_valve     <= ((nstate == EQ_IN) || (nstate == EQ_OUT)) && nxt_above;
      bus.busy            <= (nstate != IDLE);
    end
  end

endmodule
